rfphoenix_rob_sched: RTL and testbench

- Parametrised reorder/issue buffer for the barrel-threaded rfPhoenix pipeline; generalises the fixed 12-entry, lowest-index-first ROB.
- Adds configurable depth and thread count, true oldest-first issue via an age matrix, and per-thread in-order commit.
- Adds per-thread flush and multi-step re-issue for gather/scatter.
- Sits between regfetch (allocate), execute/memory units (issue/complete) and register-file writeback (commit).

---
 rtl/rfphoenix_rob_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_rfphoenix_rob_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_rob_sched.sv
// rfphoenix_rob_sched: reorder/issue buffer for the barrel-threaded rfPhoenix pipeline.
// Entries are allocated at the lowest free index. Issue picks the oldest WAIT entry,
// using an age matrix. Commit is in order within each thread and independent across
// threads. A per-thread flush is provided, and gather/scatter ops re-issue in steps.
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   alloc_v_i/rdy_o/thread_i/pay_i  allocate handshake; alloc_tag_o = lowest free index
//   iss_v_o/rdy_i/tag_o/pay_o/step_o  issue handshake to execute
//   cmp_v_i/tag_i/res_i/again_i     completion; again_i = entry must issue again
//   cmt_v_o/rdy_i/tag_o/thread_o/pay_o/res_o  commit handshake to writeback
//   flush_v_i/flush_thread_i        drop every live entry of one thread
//   count_o                         occupied entries; err_o sticky bad-completion flag
//
// Entry state:
//   state    | meaning
//   ST_EMPTY | free slot
//   ST_WAIT  | allocated, waiting to issue
//   ST_OUT   | issued, waiting for completion
//   ST_DONE  | result present, waiting to commit
module rfphoenix_rob_sched #(
  parameter int DEPTH    = 12,
  parameter int NTHREADS = 16,
  parameter int PAYW     = 256,
  parameter int RESW     = 512,
  parameter int TAGW     = $clog2(DEPTH),
  parameter int THW      = $clog2(NTHREADS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alloc_v_i,
  output logic            alloc_rdy_o,
  input  logic [THW-1:0]  alloc_thread_i,
  input  logic [PAYW-1:0] alloc_pay_i,
  output logic [TAGW-1:0] alloc_tag_o,
  output logic            iss_v_o,
  input  logic            iss_rdy_i,
  output logic [TAGW-1:0] iss_tag_o,
  output logic [PAYW-1:0] iss_pay_o,
  output logic [3:0]      iss_step_o,
  input  logic            cmp_v_i,
  input  logic [TAGW-1:0] cmp_tag_i,
  input  logic [RESW-1:0] cmp_res_i,
  input  logic            cmp_again_i,
  output logic            cmt_v_o,
  input  logic            cmt_rdy_i,
  output logic [TAGW-1:0] cmt_tag_o,
  output logic [THW-1:0]  cmt_thread_o,
  output logic [PAYW-1:0] cmt_pay_o,
  output logic [RESW-1:0] cmt_res_o,
  input  logic            flush_v_i,
  input  logic [THW-1:0]  flush_thread_i,
  output logic [TAGW:0]   count_o,
  output logic            err_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_OUT, ST_DONE} ent_st_e;

  ent_st_e          r_st   [DEPTH];
  logic [DEPTH-1:0] r_age  [DEPTH];   // r_age[i][j]: entry i is older than entry j
  logic [3:0]       r_step [DEPTH];
  logic [THW-1:0]   r_thr  [DEPTH];
  logic [PAYW-1:0]  r_pay  [DEPTH];
  logic [RESW-1:0]  r_res  [DEPTH];
  logic [TAGW:0]    r_cnt;
  logic             r_err;

  logic [DEPTH-1:0] w_valid, w_flm, w_wait, w_done, w_cmt_ok, w_cmp_hit, w_clr;
  logic [DEPTH-1:0] w_age_nx [DEPTH];
  logic [TAGW:0]    w_fl_cnt;
  logic             w_alloc_rdy, w_alloc_fire;
  logic [TAGW-1:0]  w_alloc_tag;
  logic             w_iss_v, w_iss_fire;
  logic [TAGW-1:0]  w_iss_tag;
  logic             w_cmt_v, w_cmt_fire;
  logic [TAGW-1:0]  w_cmt_tag;
  logic             w_cmp_drop, w_cmp_bad;

  // Flush mask is combinational so the flushed thread is hidden from issue/commit this cycle.
  always_comb begin
    w_valid  = '0;
    w_flm    = '0;
    w_fl_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = (r_st[i] != ST_EMPTY);
      w_flm[i]   = flush_v_i && (r_st[i] != ST_EMPTY) && (r_thr[i] == flush_thread_i);
      w_fl_cnt   = w_fl_cnt + (TAGW+1)'(w_flm[i]);
    end
  end

  always_comb begin
    w_wait = '0;
    w_done = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wait[i] = (r_st[i] == ST_WAIT) && !w_flm[i];
      w_done[i] = (r_st[i] == ST_DONE) && !w_flm[i];
    end
  end

  always_comb begin
    w_alloc_rdy = 1'b0;
    w_alloc_tag = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_alloc_rdy = 1'b1;
        w_alloc_tag = TAGW'(i);
      end
    end
  end

  // Oldest WAIT entry: no other WAIT entry has its age bit set against it.
  always_comb begin
    logic v_older;
    w_iss_v   = 1'b0;
    w_iss_tag = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      v_older = 1'b0;
      for (int j = 0; j < DEPTH; j++) v_older = v_older | (w_wait[j] & r_age[j][i]);
      if (w_wait[i] && !v_older) begin
        w_iss_v   = 1'b1;
        w_iss_tag = TAGW'(i);
      end
    end
  end

  // A DONE entry may commit once nothing older of its own thread is still live.
  always_comb begin
    logic v_blk;
    w_cmt_ok = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_blk = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        v_blk = v_blk | (w_valid[j] & r_age[j][i] & (r_thr[j] == r_thr[i]));
      w_cmt_ok[i] = w_done[i] && !v_blk;
    end
  end

  // Several threads may be committable at once; take the oldest of them.
  always_comb begin
    logic v_older;
    w_cmt_v   = 1'b0;
    w_cmt_tag = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      v_older = 1'b0;
      for (int j = 0; j < DEPTH; j++) v_older = v_older | (w_cmt_ok[j] & r_age[j][i]);
      if (w_cmt_ok[i] && !v_older) begin
        w_cmt_v   = 1'b1;
        w_cmt_tag = TAGW'(i);
      end
    end
  end

  // A completion to an entry being flushed is silently dropped rather than flagged.
  always_comb begin
    w_cmp_hit  = '0;
    w_cmp_drop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cmp_hit[i] = cmp_v_i && (cmp_tag_i == TAGW'(i)) && (r_st[i] == ST_OUT) && !w_flm[i];
      w_cmp_drop   = w_cmp_drop | (cmp_v_i && (cmp_tag_i == TAGW'(i)) && w_flm[i]);
    end
  end

  assign w_cmp_bad    = cmp_v_i && !(|w_cmp_hit) && !w_cmp_drop;
  assign w_alloc_fire = alloc_v_i && w_alloc_rdy;
  assign w_iss_fire   = w_iss_v && iss_rdy_i;
  assign w_cmt_fire   = w_cmt_v && cmt_rdy_i;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < DEPTH; i++)
      w_clr[i] = w_flm[i] | (w_cmt_fire && (w_cmt_tag == TAGW'(i)));
  end

  // A new entry is younger than every live entry; freed entries lose their row and column.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_age_nx[i] = '0;
      for (int j = 0; j < DEPTH; j++)
        w_age_nx[i][j] = (r_age[i][j] & ~w_clr[i] & ~w_clr[j])
                       | (w_alloc_fire && (w_alloc_tag == TAGW'(j)) && w_valid[i] && !w_clr[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_st[i]   <= ST_EMPTY;
        r_age[i]  <= '0;
        r_step[i] <= '0;
        r_thr[i]  <= '0;
        r_pay[i]  <= '0;
        r_res[i]  <= '0;
      end
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_cnt + (TAGW+1)'(w_alloc_fire) - (TAGW+1)'(w_cmt_fire) - w_fl_cnt;
      if (w_cmp_bad) r_err <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= w_age_nx[i];
        if (w_alloc_fire && (w_alloc_tag == TAGW'(i))) begin
          r_st[i]   <= ST_WAIT;
          r_step[i] <= '0;
          r_thr[i]  <= alloc_thread_i;
          r_pay[i]  <= alloc_pay_i;
        end else if (w_clr[i]) begin
          r_st[i] <= ST_EMPTY;
        end else if (w_iss_fire && (w_iss_tag == TAGW'(i))) begin
          r_st[i] <= ST_OUT;
        end else if (w_cmp_hit[i]) begin
          r_res[i] <= cmp_res_i;
          if (cmp_again_i) begin
            r_st[i]   <= ST_WAIT;
            r_step[i] <= (r_step[i] == 4'hF) ? 4'hF : r_step[i] + 4'd1;
          end else begin
            r_st[i] <= ST_DONE;
          end
        end
      end
    end
  end

  assign alloc_rdy_o  = w_alloc_rdy;
  assign alloc_tag_o  = w_alloc_tag;
  assign iss_v_o      = w_iss_v;
  assign iss_tag_o    = w_iss_tag;
  assign iss_pay_o    = w_iss_v ? r_pay[w_iss_tag] : '0;
  assign iss_step_o   = w_iss_v ? r_step[w_iss_tag] : 4'd0;
  assign cmt_v_o      = w_cmt_v;
  assign cmt_tag_o    = w_cmt_tag;
  assign cmt_thread_o = w_cmt_v ? r_thr[w_cmt_tag] : '0;
  assign cmt_pay_o    = w_cmt_v ? r_pay[w_cmt_tag] : '0;
  assign cmt_res_o    = w_cmt_v ? r_res[w_cmt_tag] : '0;
  assign count_o      = r_cnt;
  assign err_o        = r_err;

endmodule

// File: tb/tb_rfphoenix_rob_sched.sv
// Testbench for rfphoenix_rob_sched: directed scenarios plus random traffic, all checked
// against a reference model in which entry age is an allocation sequence number.
module tb_rfphoenix_rob_sched;
  localparam int DEPTH = 12;
  localparam int NTH   = 16;
  localparam int PAYW  = 256;
  localparam int RESW  = 512;
  localparam int TAGW  = 4;
  localparam int THW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            alloc_v_i;
  logic            alloc_rdy_o;
  logic [THW-1:0]  alloc_thread_i;
  logic [PAYW-1:0] alloc_pay_i;
  logic [TAGW-1:0] alloc_tag_o;
  logic            iss_v_o;
  logic            iss_rdy_i;
  logic [TAGW-1:0] iss_tag_o;
  logic [PAYW-1:0] iss_pay_o;
  logic [3:0]      iss_step_o;
  logic            cmp_v_i;
  logic [TAGW-1:0] cmp_tag_i;
  logic [RESW-1:0] cmp_res_i;
  logic            cmp_again_i;
  logic            cmt_v_o;
  logic            cmt_rdy_i;
  logic [TAGW-1:0] cmt_tag_o;
  logic [THW-1:0]  cmt_thread_o;
  logic [PAYW-1:0] cmt_pay_o;
  logic [RESW-1:0] cmt_res_o;
  logic            flush_v_i;
  logic [THW-1:0]  flush_thread_i;
  logic [TAGW:0]   count_o;
  logic            err_o;

  rfphoenix_rob_sched #(.DEPTH(DEPTH), .NTHREADS(NTH), .PAYW(PAYW), .RESW(RESW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_v_i(alloc_v_i), .alloc_rdy_o(alloc_rdy_o), .alloc_thread_i(alloc_thread_i),
    .alloc_pay_i(alloc_pay_i), .alloc_tag_o(alloc_tag_o),
    .iss_v_o(iss_v_o), .iss_rdy_i(iss_rdy_i), .iss_tag_o(iss_tag_o), .iss_pay_o(iss_pay_o),
    .iss_step_o(iss_step_o),
    .cmp_v_i(cmp_v_i), .cmp_tag_i(cmp_tag_i), .cmp_res_i(cmp_res_i), .cmp_again_i(cmp_again_i),
    .cmt_v_o(cmt_v_o), .cmt_rdy_i(cmt_rdy_i), .cmt_tag_o(cmt_tag_o), .cmt_thread_o(cmt_thread_o),
    .cmt_pay_o(cmt_pay_o), .cmt_res_o(cmt_res_o),
    .flush_v_i(flush_v_i), .flush_thread_i(flush_thread_i),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: 0 empty, 1 wait, 2 out, 3 done; age = allocation sequence number.
  int              m_st   [DEPTH];
  longint          m_seq  [DEPTH];
  int              m_thr  [DEPTH];
  int              m_step [DEPTH];
  logic [PAYW-1:0] m_pay  [DEPTH];
  logic [RESW-1:0] m_res  [DEPTH];
  bit              m_err;
  longint          m_seqctr;

  bit e_flm [DEPTH];
  int e_alloc, e_iss, e_cmt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [RESW-1:0] got, input logic [RESW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i] = 0; m_seq[i] = 0; m_thr[i] = 0; m_step[i] = 0; m_pay[i] = '0; m_res[i] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic calc_exp(input bit fv, input int fth);
    bit blk;
    for (int i = 0; i < DEPTH; i++) e_flm[i] = fv && (m_st[i] != 0) && (m_thr[i] == fth);
    e_alloc = -1;
    for (int i = DEPTH-1; i >= 0; i--) if (m_st[i] == 0) e_alloc = i;
    e_iss = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_st[i] == 1 && !e_flm[i] && (e_iss < 0 || m_seq[i] < m_seq[e_iss])) e_iss = i;
    e_cmt = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_st[i] == 3 && !e_flm[i]) begin
        blk = 1'b0;
        for (int j = 0; j < DEPTH; j++)
          if (m_st[j] != 0 && m_thr[j] == m_thr[i] && m_seq[j] < m_seq[i]) blk = 1'b1;
        if (!blk && (e_cmt < 0 || m_seq[i] < m_seq[e_cmt])) e_cmt = i;
      end
    end
  endtask

  task automatic check_outs();
    int              occ;
    logic [PAYW-1:0] ipay, cpay;
    logic [RESW-1:0] cres;
    int              itag, istep, ctag, cthr, atag;
    occ = 0;
    for (int i = 0; i < DEPTH; i++) if (m_st[i] != 0) occ++;
    atag = (e_alloc >= 0) ? e_alloc : 0;
    itag = 0; istep = 0; ipay = '0;
    if (e_iss >= 0) begin itag = e_iss; istep = m_step[e_iss]; ipay = m_pay[e_iss]; end
    ctag = 0; cthr = 0; cpay = '0; cres = '0;
    if (e_cmt >= 0) begin ctag = e_cmt; cthr = m_thr[e_cmt]; cpay = m_pay[e_cmt]; cres = m_res[e_cmt]; end
    chk("alloc_rdy",  RESW'(alloc_rdy_o),  RESW'(e_alloc >= 0));
    chk("alloc_tag",  RESW'(alloc_tag_o),  RESW'(atag));
    chk("iss_v",      RESW'(iss_v_o),      RESW'(e_iss >= 0));
    chk("iss_tag",    RESW'(iss_tag_o),    RESW'(itag));
    chk("iss_step",   RESW'(iss_step_o),   RESW'(istep));
    chk("iss_pay",    RESW'(iss_pay_o),    RESW'(ipay));
    chk("cmt_v",      RESW'(cmt_v_o),      RESW'(e_cmt >= 0));
    chk("cmt_tag",    RESW'(cmt_tag_o),    RESW'(ctag));
    chk("cmt_thread", RESW'(cmt_thread_o), RESW'(cthr));
    chk("cmt_pay",    RESW'(cmt_pay_o),    RESW'(cpay));
    chk("cmt_res",    cmt_res_o,           cres);
    chk("count",      RESW'(count_o),      RESW'(occ));
    chk("err",        RESW'(err_o),        RESW'(m_err));
  endtask

  task automatic zero_inputs();
    alloc_v_i = 0; alloc_thread_i = '0; alloc_pay_i = '0; iss_rdy_i = 0;
    cmp_v_i = 0; cmp_tag_i = '0; cmp_res_i = '0; cmp_again_i = 0;
    cmt_rdy_i = 0; flush_v_i = 0; flush_thread_i = '0;
  endtask

  // One clock: drive at negedge, check the combinational view, advance the model.
  task automatic cyc(input bit av, input int ath, input bit ir, input bit cv, input int ctag,
                     input bit cag, input bit cr, input bit fv, input int fth);
    @(negedge clk_i);
    alloc_v_i = av; alloc_thread_i = THW'(ath); iss_rdy_i = ir;
    cmp_v_i = cv; cmp_tag_i = TAGW'(ctag); cmp_again_i = cag; cmt_rdy_i = cr;
    flush_v_i = fv; flush_thread_i = THW'(fth);
    for (int k = 0; k < PAYW/32; k++) alloc_pay_i[k*32 +: 32] = $urandom();
    for (int k = 0; k < RESW/32; k++) cmp_res_i[k*32 +: 32] = $urandom();
    #1;
    calc_exp(fv, fth);
    check_outs();
    if (cv) begin
      if (ctag < DEPTH && e_flm[ctag]) begin
      end else if (ctag < DEPTH && m_st[ctag] == 2) begin
        m_res[ctag] = cmp_res_i;
        if (cag) begin
          m_st[ctag] = 1;
          if (m_step[ctag] < 15) m_step[ctag]++;
        end else begin
          m_st[ctag] = 3;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (ir && e_iss >= 0) m_st[e_iss] = 2;
    if (cr && e_cmt >= 0) m_st[e_cmt] = 0;
    for (int i = 0; i < DEPTH; i++) if (e_flm[i]) m_st[i] = 0;
    if (av && e_alloc >= 0) begin
      m_st[e_alloc] = 1; m_seq[e_alloc] = m_seqctr++; m_thr[e_alloc] = ath;
      m_pay[e_alloc] = alloc_pay_i; m_step[e_alloc] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sync_reset();
    @(negedge clk_i);
    zero_inputs();
    rst_ni = 0;
    #2;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic rand_cycle();
    int outs[$];
    bit cv;
    int ctag;
    outs.delete();
    for (int i = 0; i < DEPTH; i++) if (m_st[i] == 2) outs.push_back(i);
    cv = 0; ctag = 0;
    if (outs.size() > 0 && $urandom_range(99) < 60) begin
      cv = 1; ctag = outs[$urandom_range(outs.size()-1)];
    end else if ($urandom_range(99) < 2) begin
      cv = 1; ctag = $urandom_range(15);
    end
    cyc($urandom_range(99) < 50, $urandom_range(3), $urandom_range(99) < 60, cv, ctag,
        $urandom_range(99) < 30, $urandom_range(99) < 60, $urandom_range(99) < 4,
        $urandom_range(3));
  endtask

  initial begin
    m_seqctr = 0;
    zero_inputs();
    rst_ni = 0;
    model_reset();
    #12;
    calc_exp(0, 0);
    check_outs();
    @(negedge clk_i);
    rst_ni = 1;

    // In-order issue, out-of-order completion, in-order commit on one thread.
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 0);
    idle(3);

    // Full buffer: a freed slot reappears the next cycle and reissues behind older WAITs.
    sync_reset();
    for (int k = 0; k < DEPTH; k++) cyc(1, k, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 13, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Cross-thread commit independence.
    sync_reset();
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(2);

    // Gather/scatter re-issue with step saturation.
    sync_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, (k < 17), 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Flush of a thread holding WAIT/OUT/DONE with a concurrent alloc and completion.
    sync_reset();
    for (int k = 0; k < 3; k++) cyc(1, 2, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 2, 0, 1, 0, 0, 0, 1, 2);
    idle(2);

    // Random traffic.
    sync_reset();
    for (int k = 0; k < 3000; k++) rand_cycle();

    // Sticky error, then an asynchronous reset mid-cycle.
    sync_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    @(negedge clk_i);
    zero_inputs();
    #2;
    rst_ni = 0;
    #1;
    model_reset();
    calc_exp(0, 0);
    check_outs();
    @(negedge clk_i);
    rst_ni = 1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
